// File: rtl/input_pkg.sv
// Shared definitions for the arcade input mapper: keymap entry layout, scan FSM states,
// default download indices and the captured key-event payload.
package input_pkg;

    localparam int unsigned EXT_BIT = 7;
    localparam int unsigned PLY_MSB = 6;
    localparam int unsigned PLY_LSB = 5;
    localparam int unsigned BTN_MSB = 4;

    localparam logic [7:0] MAP_INDEX_DEF = 8'd253;
    localparam logic [7:0] DIP_INDEX_DEF = 8'd254;

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    typedef struct packed {
        logic       pressed;
        logic [8:0] code;
    } key_evt_t;

endpackage

// File: rtl/coin_stretch.sv
// Coin pulse shaper: a rising edge holds the output high for at least COIN_PULSE cycles,
// a re-edge restarts the hold, afterwards the output follows the input.
module coin_stretch #(
    parameter int unsigned COIN_PULSE = 100000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic in,
    output logic out
);

    localparam int unsigned CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;

    logic          in_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d = cnt_q;
        out_d = in;
        if (in && !in_q) begin
            cnt_d = CW'(COIN_PULSE - 1);
            out_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            out_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            in_q  <= 1'b0;
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            in_q  <= in;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Runtime-downloadable keymap front-end: PS/2 events are scanned against the keymap into a
// per-player key state, merged with joysticks, coin-shaped, plus a downloadable DIP bank.
module arcade_input_mapper
    import input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = 2,
    parameter int unsigned NUM_BTNS     = 12,
    parameter int unsigned COIN_IDX     = 9,
    parameter int unsigned KEYMAP_DEPTH = 32,
    parameter int unsigned COIN_PULSE   = 100000,
    parameter int unsigned DIP_BYTES    = 8,
    parameter logic [7:0]  MAP_INDEX    = MAP_INDEX_DEF,
    parameter logic [7:0]  DIP_INDEX    = DIP_INDEX_DEF
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic [10:0]                     ps2_key,
    input  logic [NUM_PLAYERS*NUM_BTNS-1:0] joy_in,
    input  logic                            ioctl_download,
    input  logic                            ioctl_wr,
    input  logic [24:0]                     ioctl_addr,
    input  logic [7:0]                      ioctl_dout,
    input  logic [7:0]                      ioctl_index,
    output logic [NUM_PLAYERS*NUM_BTNS-1:0] btn_out,
    output logic [DIP_BYTES*8-1:0]          dip_out,
    output logic                            map_ready,
    output logic                            overflow
);

    localparam int unsigned NB_ALL = NUM_PLAYERS * NUM_BTNS;
    localparam int unsigned AW     = $clog2(KEYMAP_DEPTH);
    localparam int unsigned DW     = (DIP_BYTES > 1) ? $clog2(DIP_BYTES) : 1;

    logic map_dl, map_wr, dip_wr, ev, hit;
    assign map_dl = ioctl_download && (ioctl_index == MAP_INDEX);
    assign map_wr = map_dl && ioctl_wr && (ioctl_addr < 25'(2 * KEYMAP_DEPTH));
    assign dip_wr = ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr < 25'(DIP_BYTES));

    // Keymap storage: scancode byte and attribute byte per entry, not reset.
    logic [7:0] scan_mem [KEYMAP_DEPTH];
    logic [7:0] attr_mem [KEYMAP_DEPTH];

    always_ff @(posedge Clk) begin
        if (map_wr) begin
            if (ioctl_addr[0]) attr_mem[ioctl_addr[AW:1]] <= ioctl_dout;
            else               scan_mem[ioctl_addr[AW:1]] <= ioctl_dout;
        end
    end

    state_e                  state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [KEYMAP_DEPTH-1:0] valid_q, valid_d;
    logic                    tog_q, pend_vld_q, pend_vld_d;
    key_evt_t                pend_q, pend_d, act_q, act_d;
    logic [NB_ALL-1:0]       key_q, key_d, btn_q, btn_d, raw, coin_bits;
    logic [7:0]              dip_q [DIP_BYTES];
    logic [7:0]              dip_d [DIP_BYTES];
    logic                    ready_q, ready_d, wrote_q, wrote_d, dl_q, ovf_q, ovf_d;
    logic [NUM_PLAYERS-1:0]  coin_s;
    logic [7:0]              ent_s, ent_a;

    assign ent_s = scan_mem[idx_q];
    assign ent_a = attr_mem[idx_q];
    assign hit   = valid_q[idx_q] && ({ent_a[EXT_BIT], ent_s} == act_q.code);
    assign ev    = (ps2_key[10] != tog_q) && ready_q;
    assign raw   = key_q | joy_in;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        act_d      = act_q;
        key_d      = key_q;
        dip_d      = dip_q;
        ready_d    = ready_q;
        wrote_d    = wrote_q;
        ovf_d      = ovf_q;
        btn_d      = raw;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) btn_d[p*NUM_BTNS + COIN_IDX] = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    state_d    = SCAN;
                    idx_d      = '0;
                    act_d      = pend_q;
                    pend_vld_d = 1'b0;
                end
            end
            SCAN: begin
                // Out-of-range player/button fields can never equal a loop index, so they drop out.
                for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                    for (int unsigned b = 0; b < NUM_BTNS; b++) begin
                        if (hit && ent_a[PLY_MSB:PLY_LSB] == 2'(p) && ent_a[BTN_MSB:0] == 5'(b))
                            key_d[p*NUM_BTNS + b] = act_q.pressed;
                    end
                end
                if (idx_q == AW'(KEYMAP_DEPTH - 1)) state_d = IDLE;
                else                                idx_d   = idx_q + AW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Pending is judged after the FSM, so a slot freed this cycle can be refilled.
        if (ev) begin
            if (pend_vld_d) begin
                ovf_d = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_d     = '{pressed: ps2_key[9], code: ps2_key[8:0]};
            end
        end

        if (dip_wr) dip_d[ioctl_addr[DW-1:0]] = ioctl_dout;
        if (map_wr && ioctl_addr[0]) valid_d[ioctl_addr[AW:1]] = 1'b1;

        if (map_dl) begin
            if (!dl_q)    wrote_d = 1'b0;
            if (ioctl_wr) wrote_d = 1'b1;
            ready_d    = 1'b0;
            key_d      = '0;
            state_d    = IDLE;
            pend_vld_d = 1'b0;
        end else if (dl_q) begin
            ready_d = wrote_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            valid_q    <= '0;
            tog_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            act_q      <= '0;
            key_q      <= '0;
            btn_q      <= '0;
            dip_q      <= '{default: '0};
            ready_q    <= 1'b0;
            wrote_q    <= 1'b0;
            dl_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            tog_q      <= ps2_key[10];
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            key_q      <= key_d;
            btn_q      <= btn_d;
            dip_q      <= dip_d;
            ready_q    <= ready_d;
            wrote_q    <= wrote_d;
            dl_q       <= map_dl;
            ovf_q      <= ovf_d;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
        coin_stretch #(.COIN_PULSE(COIN_PULSE)) u_coin (
            .Clk  (Clk),
            .Rst_n(Rst_n),
            .in   (raw[p*NUM_BTNS + COIN_IDX]),
            .out  (coin_s[p])
        );
    end

    always_comb begin
        coin_bits = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) coin_bits[p*NUM_BTNS + COIN_IDX] = coin_s[p];
    end

    for (genvar k = 0; k < DIP_BYTES; k++) begin : g_dip
        assign dip_out[k*8 +: 8] = dip_q[k];
    end

    assign btn_out   = btn_q | coin_bits;
    assign map_ready = ready_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed keymap/coin/DIP stimulus against a cycle-level
// model of the documented input rules, plus hand-computed literal expectations.
module tb_arcade_input_mapper;

    localparam int NP    = 2;
    localparam int NB    = 12;
    localparam int DEPTH = 32;
    localparam int PULSE = 16;
    localparam logic [23:0] COIN_MASK = 24'h200200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [23:0] joy_in = '0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic [23:0] btn_out;
    logic [63:0] dip_out;
    logic        map_ready, overflow;

    arcade_input_mapper #(.COIN_PULSE(PULSE)) dut (
        .Clk(clk), .Rst_n(rst_n), .ps2_key(ps2_key), .joy_in(joy_in),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .btn_out(btn_out), .dip_out(dip_out), .map_ready(map_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic drop_next = 1'b0;

    // Model state: what the outputs must be after each edge.
    int          cyc = 0;
    logic [7:0]  m_scan [DEPTH];
    logic [7:0]  m_attr [DEPTH];
    logic [DEPTH-1:0] m_valid = '0;
    logic [23:0] m_key = '0;
    logic [23:0] exp_btn_nc = '0;
    logic [NP-1:0] exp_coin = '0;
    logic [NP-1:0] m_raw_prev = '0;
    logic [NP-1:0] m_rise_vld = '0;
    int          m_rise [NP];
    logic [63:0] m_dip = '0;
    logic        m_ready = 1'b0, m_ovf = 1'b0, m_tog = 1'b0, m_dl_prev = 1'b0, m_wrote = 1'b0;
    int          m_settle = 0;
    int          pl, bt;
    logic        m_dl, m_ev, raw_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = '0; m_key = '0; exp_btn_nc = '0; exp_coin = '0; m_raw_prev = '0;
            m_rise_vld = '0; m_dip = '0; m_ready = 1'b0; m_ovf = 1'b0; m_tog = 1'b0;
            m_dl_prev = 1'b0; m_wrote = 1'b0; m_settle = 0;
        end else begin
            cyc++;
            m_dl = ioctl_download && (ioctl_index == 8'd253);
            exp_btn_nc = (m_key | joy_in) & ~COIN_MASK;
            for (int p = 0; p < NP; p++) begin
                raw_c = joy_in[p*NB + 9] | m_key[p*NB + 9];
                if (raw_c && !m_raw_prev[p]) begin
                    m_rise[p] = cyc;
                    m_rise_vld[p] = 1'b1;
                end
                exp_coin[p] = raw_c || (m_rise_vld[p] && (cyc - m_rise[p] < PULSE));
                m_raw_prev[p] = raw_c;
            end
            m_ev = (ps2_key[10] != m_tog) && m_ready && !m_dl;
            m_tog = ps2_key[10];
            if (m_ev) begin
                if (drop_next) begin
                    m_ovf = 1'b1;
                end else begin
                    for (int e = 0; e < DEPTH; e++) begin
                        if (m_valid[e] && {m_attr[e][7], m_scan[e]} == ps2_key[8:0]) begin
                            pl = int'(m_attr[e][6:5]);
                            bt = int'(m_attr[e][4:0]);
                            if (pl < NP && bt < NB) m_key[pl*NB + bt] = ps2_key[9];
                        end
                    end
                end
                m_settle = 2*DEPTH + 8;
            end else if (m_settle > 0) begin
                m_settle--;
            end
            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8)
                m_dip[ioctl_addr[2:0]*8 +: 8] = ioctl_dout;
            if (m_dl) begin
                if (!m_dl_prev) m_wrote = 1'b0;
                if (ioctl_wr) begin
                    m_wrote = 1'b1;
                    if (ioctl_addr < 25'(2*DEPTH)) begin
                        if (ioctl_addr[0]) begin
                            m_attr[ioctl_addr[5:1]] = ioctl_dout;
                            m_valid[ioctl_addr[5:1]] = 1'b1;
                        end else begin
                            m_scan[ioctl_addr[5:1]] = ioctl_dout;
                        end
                    end
                end
                m_ready = 1'b0;
                m_key = '0;
            end else if (m_dl_prev) begin
                m_ready = m_wrote;
            end
            m_dl_prev = m_dl;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("map_ready", 64'(map_ready), 64'(m_ready));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("dip_out", dip_out, m_dip);
        for (int p = 0; p < NP; p++) chk("coin", 64'(btn_out[p*NB + 9]), 64'(exp_coin[p]));
        if (m_settle == 0) chk("btn_nc", 64'(btn_out & ~COIN_MASK), 64'(exp_btn_nc));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            compare_model();
        end
    endtask

    task automatic key_evt(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    task automatic map_byte(input int addr, input logic [7:0] data);
        ioctl_wr = 1'b1;
        ioctl_addr = 25'(addr);
        ioctl_dout = data;
        tick(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic coin_run(input int hold, input int re, output int hi);
        hi = 0;
        for (int i = 0; i < 80; i++) begin
            joy_in[9] = (i < hold) || (i == re);
            tick(1);
            if (btn_out[9]) hi++;
        end
        joy_in[9] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    int hi;
    logic [23:0] map_bytes [12];

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("rst_btn", 64'(btn_out), 64'h0);
        chk("rst_dip", dip_out, 64'h0);
        chk("rst_ready", 64'(map_ready), 64'h0);
        chk("rst_ovf", 64'(overflow), 64'h0);

        key_evt(1'b1, 9'h029);
        tick(40);
        chk("ignored_unmapped", 64'(btn_out), 64'h0);

        coin_run(1, -1, hi);
        chk("coin_pulse_len", 64'(hi), 64'd16);
        coin_run(40, -1, hi);
        chk("coin_hold_len", 64'(hi), 64'd40);
        coin_run(1, 5, hi);
        chk("coin_reedge_len", 64'(hi), 64'd21);

        // Entries: 0 P0 F1, 5 P1 U, 6 ext P0 U, 7 bad player, 8 bad button, then out-of-range writes.
        map_bytes = '{{16'd0, 8'h29}, {16'd1, 8'h04}, {16'd10, 8'h75}, {16'd11, 8'h23},
                      {16'd12, 8'h75}, {16'd13, 8'h83}, {16'd14, 8'h1C}, {16'd15, 8'h40},
                      {16'd16, 8'h1C}, {16'd17, 8'h0D}, {16'd64, 8'h1B}, {16'd65, 8'h00}};
        ioctl_index = 8'd253;
        ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 12; i++) map_byte(int'(map_bytes[i][23:8]), map_bytes[i][7:0]);
        tick(1);
        chk("ready_during_dl", 64'(map_ready), 64'h0);
        ioctl_download = 1'b0;
        tick(1);
        chk("ready_after_dl", 64'(map_ready), 64'h1);

        key_evt(1'b1, 9'h029);
        for (int i = 0; i < 33; i++) begin
            if (btn_out[4]) break;
            tick(1);
        end
        chk("press_f1_latency", 64'(btn_out[4]), 64'h1);
        tick(40);
        chk("press_f1", 64'(btn_out), 64'h10);
        key_evt(1'b0, 9'h029);
        tick(40);
        chk("release_f1", 64'(btn_out), 64'h0);

        key_evt(1'b1, 9'h175);
        tick(40);
        chk("ext_press", 64'(btn_out), 64'h8);
        key_evt(1'b1, 9'h075);
        tick(40);
        chk("nonext_press", 64'(btn_out), 64'h8008);
        key_evt(1'b0, 9'h175);
        tick(40);
        key_evt(1'b0, 9'h075);
        tick(40);
        chk("ext_release", 64'(btn_out), 64'h0);
        key_evt(1'b1, 9'h01C);
        tick(80);
        chk("invalid_entries", 64'(btn_out), 64'h0);

        key_evt(1'b1, 9'h029);
        tick(1);
        key_evt(1'b1, 9'h175);
        tick(1);
        drop_next = 1'b1;
        key_evt(1'b1, 9'h075);
        tick(1);
        drop_next = 1'b0;
        chk("ovf_flag", 64'(overflow), 64'h1);
        tick(100);
        chk("ovf_applied", 64'(btn_out), 64'h18);

        ioctl_index = 8'd254;
        ioctl_download = 1'b1;
        map_byte(2, 8'hA5);
        chk("dip_byte2", 64'(dip_out[23:16]), 64'hA5);
        map_byte(9, 8'h3C);
        map_byte(8, 8'h3C);
        chk("dip_ignored", dip_out, 64'h0000_0000_00A5_0000);
        map_byte(7, 8'h5A);
        chk("dip_byte7", dip_out, 64'h5A00_0000_00A5_0000);
        key_evt(1'b1, 9'h075);
        map_byte(0, 8'h11);
        ioctl_download = 1'b0;
        tick(80);
        chk("concurrent_btn", 64'(btn_out), 64'h8018);
        chk("concurrent_dip", dip_out, 64'h5A00_0000_00A5_0011);
        chk("ready_kept", 64'(map_ready), 64'h1);

        key_evt(1'b0, 9'h029);
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_btn", 64'(btn_out), 64'h0);
        chk("async_rst_dip", dip_out, 64'h0);
        chk("async_rst_ready", 64'(map_ready), 64'h0);
        chk("async_rst_ovf", 64'(overflow), 64'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised keyboard, joystick and DIP input front-end for the arcade cores.
- Replaces the fixed PS/2 case-decode and button-merge logic in each core's top level with a keymap that is downloaded at runtime.
- Serves N players × M buttons, with a coin-pulse shaper and a DIP byte bank.
- Sits between hps_io and the per-game GDB port mapping.

Parameters:
- NUM_PLAYERS, 2, player count (1..4).
- NUM_BTNS, 12, buttons per player (1..32); bit order R,L,D,U,F1..F4,Start,Coin,spare.
- COIN_IDX, 9, button index that is treated as coin and pulse-shaped.
- KEYMAP_DEPTH, 32, keymap entries (power of 2, 4..64).
- COIN_PULSE, 100000, minimum coin-high time in Clk cycles (10 ms at 10 MHz).
- DIP_BYTES, 8, DIP bank size in bytes.
- MAP_INDEX, 8'd253, ioctl_index used for keymap download.
- DIP_INDEX, 8'd254, ioctl_index used for DIP download.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] toggles per event, [9] pressed, [8:0] scancode (bit 8 = extended).
- joy_in  in  NUM_PLAYERS*NUM_BTNS  active-high joystick buttons; player p occupies bits [p*NUM_BTNS +: NUM_BTNS].
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  download byte strobe.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download data.
- ioctl_index  in  8  download target.
- btn_out  out  NUM_PLAYERS*NUM_BTNS  merged active-high buttons, same layout as joy_in.
- dip_out  out  DIP_BYTES*8  DIP bank; byte k occupies [k*8 +: 8].
- map_ready  out  1  keymap loaded and usable.
- overflow  out  1  sticky flag: a key event was dropped.

Behaviour:
- Reset values:
  - btn_out = 0, dip_out = 0, map_ready = 0, overflow = 0.
  - All keymap valid bits = 0, key state = 0, coin counters = 0, FSM = IDLE.
  - Keymap RAM contents are not reset.
- Keymap entry e is 2 bytes:
  - Byte at addr 2e: scancode[7:0].
  - Byte at addr 2e+1: {ext, player[1:0], btn[4:0]}.
  - A write to addr 2e+1 sets valid[e]. Writes at addr ≥ 2*KEYMAP_DEPTH are ignored.
  - At lookup time, an entry with player ≥ NUM_PLAYERS or btn ≥ NUM_BTNS is treated as invalid.
- Map download:
  - While ioctl_download && ioctl_index==MAP_INDEX: map_ready = 0, key state is cleared, and any in-flight scan is aborted to IDLE.
  - map_ready rises 1 cycle after ioctl_download falls, provided at least one byte was written during the download.
- DIP download: ioctl_wr && ioctl_index==DIP_INDEX && addr < DIP_BYTES writes dip_out byte addr on the next edge. Higher addresses are ignored.
- Event capture:
  - A key event is a change of ps2_key[10] against its registered copy. The event captures {pressed, scancode} into a 1-deep pending register.
  - If pending is full when a new event arrives, the new event is dropped and overflow is set (cleared only by reset).
  - Events are ignored while map_ready = 0.
- FSM:
  - IDLE → SCAN when pending is valid; pending moves into the active event register in the same cycle, which frees pending.
  - SCAN visits entry i = 0..KEYMAP_DEPTH-1, one per cycle.
  - On a match (valid, {ext, scancode} equal), key_state[player][btn] <= pressed. Multiple matches all apply.
  - After the last entry: → IDLE.
  - Update latency is at most KEYMAP_DEPTH+1 cycles from the event edge when pending is empty.
- Merge: raw = key_state | joy_in. btn_out is raw registered (1 cycle), except the coin bits.
- Coin shaper (one per player, on bit COIN_IDX):
  - A rising edge of raw coin loads counter = COIN_PULSE-1 and forces btn_out coin = 1.
  - While counter ≠ 0, coin stays 1 and the counter decrements.
  - After that, coin follows raw.
  - A re-edge while counting reloads the counter. The counter saturates at 0.
- Simultaneous DIP write and key event: both proceed; they are independent.

Decomposition:
- Shared package input_pkg holds:
  - Entry field positions (EXT_BIT = 7, PLY_MSB = 6, PLY_LSB = 5, BTN_MSB = 4).
  - The FSM state enum {IDLE, SCAN}.
  - Default MAP_INDEX and DIP_INDEX.
- Sub-module coin_stretch: one instance per player, parameter COIN_PULSE; ports Clk, Rst_n, in, out.

Test Plan:
- Reset, then poll → btn_out = 0, dip_out = 0, map_ready = 0, overflow = 0. A ps2 toggle with 0x29 is ignored.
- Load map entry 0 = {0x29, 0x04} (P0 F1) and entry 5 = {0x75, 0x23} (P1 U). Drop download → map_ready = 1 one cycle later. Press 0x29 → btn_out[4] = 1 within 33 cycles. Release → 0.
- Extended key: entry {0x75, 0x83}. Press scancode 0x175 → only btn_out[3] set. Press 0x075 → unaffected by this entry.
- Coin: COIN_PULSE = 16. A 1-cycle joy_in[9] pulse → btn_out[9] high exactly 16 cycles. A 40-cycle hold → high 40 cycles.
- Three toggles within 2 cycles while scanning → first two applied, third dropped, overflow = 1.
- DIP write addr 2 = 0xA5 → dip_out[23:16] = 0xA5 next cycle. Addr 9 write → no change. Assert Rst_n = 0 mid-scan → all outputs 0 immediately.
